agregador_ejecao: RTL and testbench
===================================

# agregador_ejecao

Collects processed-pixel packets from the mesh ejection ports and serialises them into the single write stream consumed by the image collector stage. NPORTS ejection ports are arbitrated round-robin into a small FIFO. The FIFO drains at most one packet per cycle as a registered wr_en/data_out pair. Sits between the mesh edge nodes and the image collector, which has no backpressure; a hold input freezes the drain.

## Interface
- DATA_W, 14, packet width: bit DATA_W-1 = valid flag, bits [12:1] = pixel address (0..4095), bit 0 = pixel value
- NPORTS, 4, number of mesh ejection ports
- FIFO_DEPTH, 8, packet FIFO entries (power of two, ≥2)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  NPORTS  per-port packet valid
- in_data  in  NPORTS*DATA_W  per-port packets, port i at [i*DATA_W +: DATA_W]
- in_ready  out  NPORTS  per-port accept, one-hot or zero
- hold  in  1  when high, FIFO does not drain
- wr_en  out  1  one-cycle write strobe to the collector
- data_out  out  DATA_W  packet presented with wr_en
- pkt_count  out  12  packets delivered modulo 4096 (feature-gated)
- frame_done  out  1  one-cycle pulse on pkt_count wrap (feature-gated)

## Operation
- Arbiter: round-robin pointer rr (0..NPORTS-1). Search starts at rr, picks first i with in_valid[i].
- Grant only if FIFO not full. in_ready[i] is combinational: high only for the granted port. in_ready is all-zero when full or when no port is valid.
- Handshake: transfer when in_valid[i] && in_ready[i]. After a grant, rr <= granted+1 mod NPORTS. With no grant, rr is unchanged.
- Accepted packet with valid flag (bit DATA_W-1) = 0: handshake completes, packet discarded, not written to FIFO.
- Accepted packet with flag = 1: pushed to FIFO.
- Drain: each cycle, if FIFO non-empty and hold=0, pop head into data_out and assert wr_en for the next cycle. Otherwise wr_en=0 and data_out holds its last value.
- Full: push blocked even if a pop occurs the same cycle; no grant that cycle.
- Empty with simultaneous push: no bypass; the packet appears on the next drain opportunity.
- Simultaneous push and pop when not full: both occur, occupancy unchanged.
- Occupancy counter width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (rst=0, async): FIFO empty, pointers 0, rr=0, wr_en=0, data_out=0, pkt_count=0, frame_done=0. in_ready=0 while rst=0.
- In-flight FIFO contents are discarded on reset. The first post-reset grant comes in the first cycle with rst=1.
- Latency: handshake in cycle N, then FIFO write at edge ending N, pop at edge ending N+1, wr_en high in cycle N+2.
- Throughput: 1 packet/cycle sustained with hold=0.
- hold: takes effect at the next edge. A wr_en already asserted completes its single cycle.

## Configuration
- AGREGADOR_CONTADOR_EN defined:
  - pkt_count increments on every wr_en cycle, wrapping 4095→0.
  - frame_done pulses high the cycle after the 4096th write of a frame, concurrent with pkt_count returning to 0.
- Undefined: both ports exist and are tied to 0; no counter logic is generated.

## Structure
- Package agregador_pkg holds:
  - DATA_W
  - field positions: VALID_BIT, ADDR_MSB=12, ADDR_LSB=1, PIX_BIT=0
  - IMG_PIXELS=4096
- Sub-module fifo_pacotes: synchronous FIFO with push/pop/full/empty and async active-low reset.
- Arbiter and drain register stay in the top module.

## Test plan
- Reset release, single packet 14'h2003 on port 2: in_ready[2] high same cycle; wr_en high exactly 2 cycles later with data_out=14'h2003.
- Fairness, all four ports valid continuously: grants follow 0,1,2,3,0,… and wr_en stays high every cycle from cycle 2 on.
- Flag-0 packet 14'h0005 on port 1: in_ready[1] pulses once; wr_en never asserts for it.
- Full: hold=1 with continuous input; after 8 accepts in_ready stays 0. Release hold: 8 consecutive wr_en pulses in FIFO order, then accepts resume.
- Reset mid-stream, rst=0 with 5 packets queued: wr_en and data_out go to 0 immediately, no stale packet emerges after release.
- With AGREGADOR_CONTADOR_EN, 4096 flagged packets: pkt_count reads 4095 after the 4095th write; frame_done pulses once on the 4096th and pkt_count=0.

Source files
------------

// File: rtl/agregador_pkg.sv
// ============================================================================
// agregador_pkg : shared packet layout and frame constants for the
//                 mesh ejection aggregator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package agregador_pkg;

  localparam int DATA_W     = 14;
  localparam int VALID_BIT  = DATA_W - 1;
  localparam int ADDR_MSB   = 12;
  localparam int ADDR_LSB   = 1;
  localparam int PIX_BIT    = 0;
  localparam int IMG_PIXELS = 4096;
  localparam int CNT_W      = $clog2(IMG_PIXELS);

  typedef logic [DATA_W-1:0] pkt_t;

  function automatic logic pkt_flag(input pkt_t p);
    return p[VALID_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_pacotes.sv
// ============================================================================
// fifo_pacotes : synchronous packet FIFO, async active-low reset, no bypass.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_pacotes
  import agregador_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  pkt_t din,
  output pkt_t dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  pkt_t             mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/agregador_ejecao.sv
// ============================================================================
// agregador_ejecao : round-robin merge of mesh ejection ports into one
//                    registered write stream. Optional packet/frame counter
//                    enabled by AGREGADOR_CONTADOR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module agregador_ejecao
  import agregador_pkg::*;
#(
  parameter int NPORTS     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*DATA_W-1:0] in_data,
  output logic [NPORTS-1:0]        in_ready,
  input  logic                     hold,
  output logic                     wr_en,
  output logic [DATA_W-1:0]        data_out,
  output logic [CNT_W-1:0]         pkt_count,
  output logic                     frame_done
);

  localparam int RR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  logic [RR_W-1:0] rr_q, rr_d, grant_idx;
  logic [RR_W:0]   scan;
  logic            grant_found, grant, push, pop;
  logic            fifo_full, fifo_empty;
  pkt_t            granted_pkt, fifo_dout;
  logic            wr_en_q;
  pkt_t            data_out_q;

  // First valid port at or after rr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_q;
    scan        = '0;
    for (int k = 0; k < NPORTS; k++) begin
      scan = {1'b0, rr_q} + (RR_W+1)'(k);
      if (scan >= (RR_W+1)'(NPORTS)) scan = scan - (RR_W+1)'(NPORTS);
      if (!grant_found && in_valid[scan[RR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[RR_W-1:0];
      end
    end
  end

  assign grant       = grant_found && !fifo_full && rst;
  assign in_ready    = grant ? (NPORTS'(1) << grant_idx) : '0;
  assign granted_pkt = in_data[grant_idx*DATA_W +: DATA_W];
  assign push        = grant && pkt_flag(granted_pkt);
  assign pop         = !fifo_empty && !hold;

  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = (grant_idx == RR_W'(NPORTS-1)) ? '0 : grant_idx + 1'b1;
  end

  fifo_pacotes #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (granted_pkt),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q       <= '0;
      wr_en_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      rr_q    <= rr_d;
      wr_en_q <= pop;
      if (pop) data_out_q <= fifo_dout;
    end
  end

  assign wr_en    = wr_en_q;
  assign data_out = data_out_q;

`ifdef AGREGADOR_CONTADOR_EN
  logic [CNT_W-1:0] pkt_count_q;
  logic             frame_done_q;

  // frame_done lands together with the counter wrapping back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wr_en_q && (pkt_count_q == CNT_W'(IMG_PIXELS-1));
      if (wr_en_q) pkt_count_q <= pkt_count_q + 1'b1;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign frame_done = frame_done_q;
`else
  assign pkt_count  = '0;
  assign frame_done = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_agregador_ejecao.sv
// ============================================================================
// tb_agregador_ejecao : scoreboard bench for agregador_ejecao.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_agregador_ejecao;
  import agregador_pkg::*;

  localparam int NP    = 4;
  localparam int DEPTH = 8;
  localparam int DW    = DATA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      in_valid;
  logic [NP*DW-1:0]   in_data;
  logic [NP-1:0]      in_ready;
  logic               hold;
  logic               wr_en;
  logic [DW-1:0]      data_out;
  logic [CNT_W-1:0]   pkt_count;
  logic               frame_done;

  always #5 clk = ~clk;

  agregador_ejecao #(.NPORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .hold       (hold),
    .wr_en      (wr_en),
    .data_out   (data_out),
    .pkt_count  (pkt_count),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // staged stimulus for the next cycle
  logic [NP-1:0] s_valid;
  logic [DW-1:0] s_pk [NP];
  logic          s_hold;

  // reference model state
  int            rr_m, cnt_m, writes_m, obs_grant;
  bit            exp_wr, prev_wr;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic logic [DW-1:0] rnd_pkt(input bit flag);
    logic [11:0] a;
    logic        p;
    a = 12'($urandom);
    p = 1'($urandom);
    return {flag, a, p};
  endfunction

  task automatic model_clear();
    sb.delete();
    cnt_m = 0; rr_m = 0; writes_m = 0;
    exp_wr = 0; prev_wr = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_en",      32'(wr_en),      32'd0);
    chk("rst_data_out",   32'(data_out),   32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_pkt_count",  32'(pkt_count),  32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  task automatic cycle();
    int            g;
    int            push_m;
    int            pop_m;
    logic [NP-1:0] exp_rdy;
    @(negedge clk);
    in_valid = s_valid;
    hold     = s_hold;
    for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = s_pk[i];
    #1;
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (wr_en && sb.size() > 0) chk("data_out", 32'(data_out), 32'(sb.pop_front()));
`ifdef AGREGADOR_CONTADOR_EN
    chk("pkt_count",  32'(pkt_count),  32'(writes_m % IMG_PIXELS));
    chk("frame_done", 32'(frame_done),
        (prev_wr && writes_m > 0 && (writes_m % IMG_PIXELS) == 0) ? 32'd1 : 32'd0);
`else
    chk("pkt_count_tied",  32'(pkt_count),  32'd0);
    chk("frame_done_tied", 32'(frame_done), 32'd0);
`endif
    g = -1;
    if (cnt_m < DEPTH) begin
      for (int k = 0; k < NP; k++) begin
        int idx = (rr_m + k) % NP;
        if (g < 0 && s_valid[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? NP'(1 << g) : '0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    obs_grant = -1;
    for (int i = 0; i < NP; i++) if (in_ready[i]) obs_grant = i;
    pop_m  = (cnt_m > 0 && !s_hold) ? 1 : 0;
    push_m = 0;
    if (g >= 0) begin
      rr_m = (g + 1) % NP;
      if (s_pk[g][DW-1]) begin
        sb.push_back(s_pk[g]);
        push_m = 1;
      end
    end
    cnt_m  += push_m - pop_m;
    prev_wr = wr_en;
    if (wr_en) writes_m++;
    exp_wr  = (pop_m != 0);
  endtask

  task automatic idle(input int n);
    s_valid = '0;
    s_hold  = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    s_valid  = '0;
    rst      = 1'b1;
  endtask

  int n_acc;

  initial begin
    rst      = 1'b0;
    in_valid = '1;
    in_data  = '1;
    hold     = 1'b0;
    s_valid  = '0;
    s_hold   = 1'b0;
    for (int i = 0; i < NP; i++) s_pk[i] = '0;
    model_clear();
    #3;
    chk_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = '0;
    rst      = 1'b1;

    // single flagged packet on port 2
    s_valid = 4'b0100;
    s_pk[2] = 14'h2003;
    cycle();
    chk("single_grant", 32'(obs_grant), 32'd2);
    idle(4);

    // fairness with all ports valid, starting from rr = 0
    do_reset();
    s_valid = '1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NP; i++) s_pk[i] = rnd_pkt(1'b1);
      cycle();
      chk("rr_order", 32'(obs_grant), 32'(c % NP));
    end
    idle(4);

    // flag-0 packet is accepted and dropped
    s_valid = 4'b0010;
    s_pk[1] = 14'h0005;
    cycle();
    chk("flag0_grant", 32'(obs_grant), 32'd1);
    idle(4);

    // fill under hold, then drain
    s_hold  = 1'b1;
    s_valid = '1;
    n_acc   = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NP; i++) s_pk[i] = rnd_pkt(1'b1);
      cycle();
      if (obs_grant >= 0) n_acc++;
    end
    chk("full_accepts", 32'(n_acc), 32'd8);
    s_hold = 1'b0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NP; i++) s_pk[i] = rnd_pkt(1'b1);
      cycle();
    end
    idle(12);

    // reset while packets are queued and one is on the output
    s_hold  = 1'b1;
    s_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      s_pk[0] = rnd_pkt(1'b1);
      cycle();
    end
    s_valid = '0;
    s_hold  = 1'b0;
    cycle();
    cycle();
    s_valid = '1;
    do_reset();
    idle(6);

    // long random run, crosses a full frame of writes
    for (int c = 0; c < 5000; c++) begin
      s_valid = NP'($urandom_range(1, (1 << NP) - 1));
      for (int i = 0; i < NP; i++) s_pk[i] = rnd_pkt($urandom_range(0, 15) != 0);
      s_hold = ($urandom_range(0, 31) == 0);
      cycle();
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
